spi_job_master: RTL and testbench

SPI master that drives the miner's serial link from the host/controller side. It shifts a 768-bit job (256-bit midstate followed by the 512-bit second block) out on mosi_bit. During the first 256 bits of the same frame it captures the 256-bit SHA-256 result returned on miso_bit. It generates the serial clock and the active-low chip enable, and presents a start/busy/done handshake to the local controller.

---
 rtl/spi_job_master.sv | 128 ++++++++++++
 tb/tb_spi_job_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_job_master.sv
// SPI mode-0 master: shifts a FRAME_BITS job out on mosi_bit and captures the first RESULT_BITS miso bits.
// Accept-to-done is 2*HALF_PERIOD*(FRAME_BITS+1) cycles; start is ignored while busy.
module spi_job_master #(
  parameter int FRAME_BITS  = 768,
  parameter int RESULT_BITS = 256,
  parameter int HALF_PERIOD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [0:FRAME_BITS-1]  mosi_message,
  output logic                   busy,
  output logic                   done,
  output logic [0:RESULT_BITS-1] miso_result,
  output logic                   sclk,
  output logic                   chip_enable,
  output logic                   mosi_bit,
  input  logic                   miso_bit
);

  localparam int CW = $clog2(FRAME_BITS) + 1;
  localparam int DW = $clog2(HALF_PERIOD) + 1;

  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] RES_LAST   = CW'(RESULT_BITS - 1);
  localparam logic [DW-1:0] HP_LAST    = DW'(HALF_PERIOD - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]             state;
  logic [CW-1:0]          bit_cnt;
  logic [DW-1:0]          div;
  logic [0:FRAME_BITS-1]  tx;
  logic [0:RESULT_BITS-1] rx;

  logic half_end;
  assign half_end = (div == HP_LAST);

  // tx[0] is always the bit on the wire; the register drains to zero by the end of a frame
  assign mosi_bit = tx[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      div         <= '0;
      tx          <= '0;
      rx          <= '0;
      sclk        <= 1'b0;
      chip_enable <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      miso_result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          div <= '0;
          if (start) begin
            tx          <= mosi_message;
            bit_cnt     <= '0;
            chip_enable <= 1'b0;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (half_end) begin
            div   <= '0;
            state <= SHIFT;
          end else begin
            div <= div + DW'(1);
          end
        end
        SHIFT: begin
          if (half_end) begin
            div <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              if (bit_cnt <= RES_LAST) begin
                rx <= {rx[1:RESULT_BITS-1], miso_bit};
              end
            end else begin
              sclk <= 1'b0;
              tx   <= {tx[1:FRAME_BITS-1], 1'b0};
              if (bit_cnt == FRAME_LAST) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        HOLD: begin
          if (half_end) begin
            div         <= '0;
            chip_enable <= 1'b1;
            miso_result <= rx;
            done        <= 1'b1;
            state       <= GAP;
          end else begin
            div <= div + DW'(1);
          end
        end
        GAP: begin
          if (half_end) begin
            div   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            div <= div + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          div   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_job_master.sv
// Directed bench: three masters (HALF_PERIOD 2, 1, 5) each with a mode-0 slave model and an edge monitor.
`timescale 1ns/1ps
module tb_spi_job_master;

  localparam logic [0:767] MSG_A = {12{64'h0123456789ABCDEF}};
  localparam logic [0:767] MSG_B = {24{32'hF0E1D2C3}};
  localparam logic [0:255] RES_A =
    256'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0_0F1E2D3C_4B5A6978_8796A5B4_C3D2A5A5;
  localparam logic [0:255] RES_B =
    256'h01234567_89ABCDEF_FEDCBA98_76543210_A5A5A5A5_C3C3C3C3_96969696_DEADBEEF;

  logic clk = 1'b0;
  logic rst;
  logic         start_s [3];
  logic [0:767] msg_s   [3];
  logic         busy_s  [3];
  logic         done_s  [3];
  logic [0:255] res_s   [3];
  logic         sclk_s  [3];
  logic         ce_s    [3];
  logic         mosi_s  [3];
  logic         miso_s  [3] = '{1'b0, 1'b0, 1'b0};
  logic [0:255] slave_res [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int HP = (g == 1) ? 1 : ((g == 2) ? 5 : 2);
    spi_job_master #(.FRAME_BITS(768), .RESULT_BITS(256), .HALF_PERIOD(HP)) u_dut (
      .clk(clk), .rst(rst), .start(start_s[g]), .mosi_message(msg_s[g]),
      .busy(busy_s[g]), .done(done_s[g]), .miso_result(res_s[g]),
      .sclk(sclk_s[g]), .chip_enable(ce_s[g]), .mosi_bit(mosi_s[g]), .miso_bit(miso_s[g])
    );
  end

  function automatic int hp_of(input int i);
    return (i == 1) ? 1 : ((i == 2) ? 5 : 2);
  endfunction

  // Monitor + slave, evaluated 1ns after each rising clk edge
  int cyc = 0;
  int ridx [3] = '{0, 0, 0};
  int stable [3] = '{0, 0, 0};
  int ce_run [3] = '{0, 0, 0};
  int ce_gap [3] = '{0, 0, 0};
  int last_rise [3] = '{0, 0, 0};
  int setup_viol [3] = '{0, 0, 0};
  int period_viol [3] = '{0, 0, 0};
  int accept_cyc [3] = '{0, 0, 0};
  int done_cyc [3] = '{0, 0, 0};
  int done_tot [3] = '{0, 0, 0};
  logic [0:767] mosi_cap [3];
  logic p_ce [3], p_sclk [3], p_mosi [3], p_busy [3];

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (ce_s[i] === 1'b0 && p_ce[i] === 1'b1) begin
        ridx[i]   = 0;
        ce_gap[i] = ce_run[i];
        miso_s[i] = slave_res[i][0];
      end
      if (ce_s[i] === 1'b1) ce_run[i]++; else ce_run[i] = 0;
      if (mosi_s[i] !== p_mosi[i]) stable[i] = 0; else stable[i]++;
      if (sclk_s[i] === 1'b1 && p_sclk[i] === 1'b0) begin
        if (ridx[i] < 768) mosi_cap[i][ridx[i][9:0]] = mosi_s[i];
        if (stable[i] < hp_of(i)) setup_viol[i]++;
        if (ridx[i] > 0 && (cyc - last_rise[i]) != 2 * hp_of(i)) period_viol[i]++;
        last_rise[i] = cyc;
        ridx[i]++;
        miso_s[i] = (ridx[i] < 256) ? slave_res[i][ridx[i][7:0]] : 1'b0;
      end
      if (busy_s[i] === 1'b1 && p_busy[i] !== 1'b1) accept_cyc[i] = cyc;
      if (done_s[i] === 1'b1) begin
        done_cyc[i] = cyc;
        done_tot[i]++;
      end
      p_ce[i]   = ce_s[i];
      p_sclk[i] = sclk_s[i];
      p_mosi[i] = mosi_s[i];
      p_busy[i] = busy_s[i];
    end
  end

  // Stimulus helper: accepts one frame, optionally re-pulses start at k==10 and k==late, waits for done.
  task automatic run_frame(input int i, input logic [0:767] msg, input logic [0:255] res,
                           input bit repulse, input int late, output bit ok);
    int k;
    msg_s[i] = msg;
    slave_res[i] = res;
    start_s[i] = 1'b1;
    @(negedge clk);
    ok = 1'b0;
    k = 0;
    while (k < 20000 && !ok) begin
      start_s[i] = (repulse && (k == 10 || k == late)) ? 1'b1 : 1'b0;
      @(negedge clk);
      k++;
      if (done_s[i] === 1'b1) ok = 1'b1;
    end
    start_s[i] = 1'b0;
    repeat (hp_of(i) + 3) @(negedge clk);
  endtask

  task automatic wait_level(input int i, input bit want_busy, output bit ok);
    int k;
    k = 0;
    while (k < 20000 && busy_s[i] !== want_busy) begin
      @(negedge clk);
      k++;
    end
    ok = (busy_s[i] === want_busy);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_s[0] = 1'b1;
    msg_s[0] = MSG_A;
    slave_res[0] = RES_A;
    repeat (3) @(negedge clk);
    checks++; if (ce_s[0] !== 1'b1) begin errors++; $display("FAIL reset_ce: got %b want 1", ce_s[0]); end
    checks++; if (sclk_s[0] !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk_s[0]); end
    checks++; if (busy_s[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_s[0]); end
    checks++; if (done_s[0] !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_s[0]); end
    checks++; if (mosi_s[0] !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi_s[0]); end
    checks++; if (res_s[0] !== 256'h0) begin errors++; $display("FAIL reset_result: got %h want 0", res_s[0]); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy_s[0] !== 1'b1 || ce_s[0] !== 1'b0) begin
      errors++; $display("FAIL accept_after_reset: busy=%b ce=%b want busy=1 ce=0", busy_s[0], ce_s[0]);
    end
    start_s[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame;
    bit ok;
    int d0;
    d0 = done_tot[0];
    run_frame(0, MSG_A, RES_A, 1'b0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: no done within budget"); end
    checks++; if (done_cyc[0] - accept_cyc[0] !== 3076) begin
      errors++; $display("FAIL single_latency: got %0d want 3076", done_cyc[0] - accept_cyc[0]);
    end
    checks++; if (ridx[0] !== 768) begin errors++; $display("FAIL single_rises: got %0d want 768", ridx[0]); end
    checks++; if (mosi_cap[0] !== MSG_A) begin errors++; $display("FAIL single_mosi: got %h want %h", mosi_cap[0], MSG_A); end
    checks++; if (res_s[0] !== RES_A) begin errors++; $display("FAIL single_result: got %h want %h", res_s[0], RES_A); end
    checks++; if (done_tot[0] - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_tot[0] - d0); end
    checks++; if (ce_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
      errors++; $display("FAIL single_idle: ce=%b busy=%b want ce=1 busy=0", ce_s[0], busy_s[0]);
    end
  endtask

  task automatic test_ignore_start;
    bit ok;
    int d0;
    d0 = done_tot[0];
    run_frame(0, MSG_B, RES_B, 1'b1, 3075, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ignore_timeout: no done within budget"); end
    checks++; if (done_cyc[0] - accept_cyc[0] !== 3076) begin
      errors++; $display("FAIL ignore_latency: got %0d want 3076", done_cyc[0] - accept_cyc[0]);
    end
    checks++; if (done_tot[0] - d0 !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", done_tot[0] - d0); end
    checks++; if (busy_s[0] !== 1'b0) begin errors++; $display("FAIL ignore_restart: busy=%b want 0", busy_s[0]); end
    checks++; if (mosi_cap[0] !== MSG_B) begin errors++; $display("FAIL ignore_mosi: got %h want %h", mosi_cap[0], MSG_B); end
    checks++; if (res_s[0] !== RES_B) begin errors++; $display("FAIL ignore_result: got %h want %h", res_s[0], RES_B); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int d1;
    msg_s[0] = MSG_A;
    slave_res[0] = RES_A;
    start_s[0] = 1'b1;
    @(negedge clk);
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      if (done_s[0] === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: no done within budget"); end
    d1 = done_cyc[0];
    msg_s[0] = MSG_B;
    slave_res[0] = RES_B;
    checks++; if (res_s[0] !== RES_A) begin errors++; $display("FAIL b2b_first_result: got %h want %h", res_s[0], RES_A); end
    wait_level(0, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_busy_fall: busy never fell"); end
    wait_level(0, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_busy_rise: second frame not accepted"); end
    start_s[0] = 1'b0;
    checks++; if (accept_cyc[0] - d1 !== 3) begin
      errors++; $display("FAIL b2b_gap: accept %0d cycles after done, want 3", accept_cyc[0] - d1);
    end
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      if (done_s[0] === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout: no done within budget"); end
    repeat (5) @(negedge clk);
    checks++; if (ce_gap[0] < 2) begin errors++; $display("FAIL b2b_deselect: ce high %0d cycles, want >= 2", ce_gap[0]); end
    checks++; if (mosi_cap[0] !== MSG_B) begin errors++; $display("FAIL b2b_mosi: got %h want %h", mosi_cap[0], MSG_B); end
    checks++; if (res_s[0] !== RES_B) begin errors++; $display("FAIL b2b_second_result: got %h want %h", res_s[0], RES_B); end
  endtask

  task automatic test_mid_frame_reset;
    bit ok;
    int d0;
    d0 = done_tot[0];
    msg_s[0] = MSG_B;
    slave_res[0] = RES_A;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int k = 0; k < 5000 && ridx[0] < 300; k++) @(negedge clk);
    checks++; if (ridx[0] !== 300) begin errors++; $display("FAIL midrst_reach: bit %0d want 300", ridx[0]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ce_s[0] !== 1'b1 || sclk_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: ce=%b sclk=%b busy=%b want 1 0 0", ce_s[0], sclk_s[0], busy_s[0]);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (done_tot[0] - d0 !== 0) begin errors++; $display("FAIL midrst_done: got %0d pulses want 0", done_tot[0] - d0); end
    checks++; if (res_s[0] !== 256'h0) begin errors++; $display("FAIL midrst_result: got %h want 0", res_s[0]); end
    run_frame(0, MSG_A, RES_B, 1'b0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_refr_timeout: no done within budget"); end
    checks++; if (mosi_cap[0] !== MSG_A) begin errors++; $display("FAIL midrst_refr_mosi: got %h want %h", mosi_cap[0], MSG_A); end
    checks++; if (res_s[0] !== RES_B) begin errors++; $display("FAIL midrst_refr_result: got %h want %h", res_s[0], RES_B); end
  endtask

  task automatic test_half_period(input int i, input int want_lat);
    bit ok;
    int sv, pv;
    sv = setup_viol[i];
    pv = period_viol[i];
    run_frame(i, MSG_A, RES_A, 1'b0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hp%0d_timeout: no done within budget", hp_of(i)); end
    checks++; if (done_cyc[i] - accept_cyc[i] !== want_lat) begin
      errors++; $display("FAIL hp%0d_latency: got %0d want %0d", hp_of(i), done_cyc[i] - accept_cyc[i], want_lat);
    end
    checks++; if (period_viol[i] - pv !== 0) begin
      errors++; $display("FAIL hp%0d_period: %0d sclk periods not %0d cycles", hp_of(i), period_viol[i] - pv, 2 * hp_of(i));
    end
    checks++; if (setup_viol[i] - sv !== 0) begin
      errors++; $display("FAIL hp%0d_setup: %0d rising edges with short mosi setup", hp_of(i), setup_viol[i] - sv);
    end
    checks++; if (ridx[i] !== 768) begin errors++; $display("FAIL hp%0d_rises: got %0d want 768", hp_of(i), ridx[i]); end
    checks++; if (mosi_cap[i] !== MSG_A) begin errors++; $display("FAIL hp%0d_mosi: got %h want %h", hp_of(i), mosi_cap[i], MSG_A); end
    checks++; if (res_s[i] !== RES_A) begin errors++; $display("FAIL hp%0d_result: got %h want %h", hp_of(i), res_s[i], RES_A); end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      msg_s[i] = '0;
      slave_res[i] = '0;
    end
    test_reset();
    test_single_frame();
    test_ignore_start();
    test_back_to_back();
    test_mid_frame_reset();
    test_half_period(0, 3076);
    test_half_period(1, 1538);
    test_half_period(2, 7690);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
